// File: rtl/prog_chain_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_chain_loader
// Function : Byte-stream to serial configuration-chain loader driving
//            prog_in / prog_clk / prog_en, one prog_clk rise per chain bit.
// Options  : PROG_READBACK_EN adds rd_data / rd_valid tail-bit readback.
// Revision : 1.0 - initial release
// ============================================================================
module prog_chain_loader #(
  parameter int CHAIN_LEN = 24,
  parameter int DIV       = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] cfg_data,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  output logic       prog_in,
  output logic       prog_clk,
  output logic       prog_en,
  input  logic       prog_out,
  output logic       busy,
  output logic       done,
  output logic       err
`ifdef PROG_READBACK_EN
  ,
  output logic [7:0] rd_data,
  output logic       rd_valid
`endif
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int DIV_W = $clog2(DIV + 1);

  localparam logic [CNT_W-1:0] C_CHAIN_LEN = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] C_LAST_BIT  = CNT_W'(1);
  localparam logic [DIV_W-1:0] C_DIV_LAST  = DIV_W'(DIV - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_LO     = 3'd2;
  localparam logic [2:0] S_HI     = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div;
  logic [7:0]       r_byte;
  logic [2:0]       r_idx;
  logic [2:0]       w_idx_inc;
  logic             w_abort;
  logic             w_hs;
  logic             w_phase_end;
  logic             w_hi_exit;
  logic             w_last_bit;
  logic             w_busy_next;

  assign w_abort     = abort && (r_state != S_IDLE);
  assign w_hs        = (r_state == S_FETCH) && cfg_valid && !abort;
  assign w_phase_end = (r_div == C_DIV_LAST);
  assign w_hi_exit   = (r_state == S_HI) && w_phase_end && !abort;
  assign w_last_bit  = (r_cnt == C_LAST_BIT);
  assign w_idx_inc   = r_idx + 3'd1;
  assign w_busy_next = (w_next == S_FETCH) || (w_next == S_LO) || (w_next == S_HI);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_FETCH;
      S_FETCH:  if (cfg_valid) w_next = S_LO;
      S_LO:     if (w_phase_end) w_next = S_HI;
      S_HI: begin
        if (w_phase_end) begin
          if (w_last_bit)         w_next = S_FINISH;
          else if (r_idx == 3'd7) w_next = S_FETCH;
          else                    w_next = S_LO;
        end
      end
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_IDLE;
  end

  // Outputs are registered decodes of the next state so prog_clk is glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_div     <= '0;
      r_byte    <= '0;
      r_idx     <= '0;
      prog_in   <= 1'b0;
      prog_clk  <= 1'b0;
      prog_en   <= 1'b0;
      cfg_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      r_state   <= w_next;
      prog_clk  <= (w_next == S_HI);
      prog_en   <= w_busy_next;
      busy      <= w_busy_next;
      cfg_ready <= (w_next == S_FETCH);
      done      <= (w_next == S_FINISH);
      err       <= w_abort;

      if (w_next != r_state)
        r_div <= '0;
      else if ((r_state == S_LO) || (r_state == S_HI))
        r_div <= r_div + 1'b1;

      if ((r_state == S_IDLE) && start)
        r_cnt <= C_CHAIN_LEN;
      else if (w_hi_exit)
        r_cnt <= r_cnt - 1'b1;

      // prog_in only moves on entry to LO, never while prog_clk is high.
      if (w_hs) begin
        r_byte  <= cfg_data;
        r_idx   <= 3'd0;
        prog_in <= cfg_data[0];
      end else if (w_hi_exit && !w_last_bit && (r_idx != 3'd7)) begin
        r_idx   <= w_idx_inc;
        prog_in <= r_byte[w_idx_inc];
      end
    end
  end

`ifdef PROG_READBACK_EN
  logic [7:0] r_rd_shift;
  logic [2:0] r_rd_cnt;
  logic       w_sample;

  // Tail bit is sampled in the last LO cycle, just before the chain shifts.
  assign w_sample = (r_state == S_LO) && w_phase_end && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_shift <= '0;
      r_rd_cnt   <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (w_abort) begin
        r_rd_shift <= '0;
        r_rd_cnt   <= '0;
      end else if (w_sample) begin
        if (r_rd_cnt == 3'd7) begin
          rd_data    <= {prog_out, r_rd_shift[6:0]};
          rd_valid   <= 1'b1;
          r_rd_shift <= '0;
          r_rd_cnt   <= '0;
        end else begin
          r_rd_shift[r_rd_cnt] <= prog_out;
          r_rd_cnt             <= r_rd_cnt + 3'd1;
        end
      end else if (w_hi_exit && w_last_bit && (r_rd_cnt != 3'd0)) begin
        rd_data    <= r_rd_shift;
        rd_valid   <= 1'b1;
        r_rd_shift <= '0;
        r_rd_cnt   <= '0;
      end
    end
  end
`else
  logic w_prog_out_unused;
  assign w_prog_out_unused = prog_out;
`endif

endmodule
`default_nettype wire

// File: tb/tb_prog_chain_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_prog_chain_loader
// Function : Randomized bench for prog_chain_loader with a behavioural
//            shift-register chain and stream-level expected contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_chain_loader;

  localparam int L  = 20;
  localparam int D  = 3;
  localparam int NB = (L + 7) / 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] cfg_data = 8'h00;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready, prog_in, prog_clk, prog_en, prog_out, busy, done, err;
`ifdef PROG_READBACK_EN
  logic [7:0] rd_data;
  logic       rd_valid;
`endif

  always #5 clk = ~clk;

  prog_chain_loader #(.CHAIN_LEN(L), .DIV(D)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .cfg_data  (cfg_data),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .prog_in   (prog_in),
    .prog_clk  (prog_clk),
    .prog_en   (prog_en),
    .prog_out  (prog_out),
    .busy      (busy),
    .done      (done),
    .err       (err)
`ifdef PROG_READBACK_EN
    ,
    .rd_data   (rd_data),
    .rd_valid  (rd_valid)
`endif
  );

  // Behavioural chain: head at bit 0, tail at bit L-1.
  logic [L-1:0] chain = '0;
  always @(posedge prog_clk) if (prog_en) chain <= {chain[L-2:0], prog_in};
  assign prog_out = chain[L-1];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Monitors
  int hs_cnt = 0;
  always @(posedge clk) if (rst_n && cfg_valid && cfg_ready) hs_cnt++;

  int rises = 0, dones = 0, errs = 0, hi_len = 0, lo_len = 0, hs_at_fall = 0;
  int bad_hi = 0, bad_lo = 0, bad_hold = 0;
  logic prev_pclk = 1'b0, pin_rise = 1'b0;
  always @(negedge clk) begin
    if (done) dones++;
    if (err)  errs++;
    if (prog_clk) begin
      if (!prev_pclk) begin
        rises++;
        hi_len   = 1;
        pin_rise = prog_in;
        if (hs_cnt == hs_at_fall && lo_len != D) bad_lo++;
      end else begin
        hi_len++;
        if (prog_in !== pin_rise) bad_hold++;
      end
    end else begin
      if (prev_pclk) begin
        if (!err && hi_len != D) bad_hi++;
        lo_len     = 1;
        hs_at_fall = hs_cnt;
      end else begin
        lo_len++;
      end
    end
    prev_pclk = prog_clk;
  end

`ifdef PROG_READBACK_EN
  int rd_n = 0;
  logic [7:0] rd_buf [16];
  always @(negedge clk) if (rd_valid) begin rd_buf[rd_n % 16] = rd_data; rd_n++; end

  function automatic logic [7:0] rb_exp(input logic [L-1:0] pre, input int bi);
    logic [7:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) if (bi * 8 + k < L) r[k] = pre[L-1-(bi*8+k)];
    return r;
  endfunction
`endif

  logic [7:0] stim [NB];
  int stall_bad = 0;

  // After a full load, stream bit k has been shifted to position L-1-k.
  function automatic logic [L-1:0] stream_chain();
    logic [L-1:0] e;
    for (int k = 0; k < L; k++) e[L-1-k] = stim[k/8][k%8];
    return e;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int maxd);
    int t, dly;
    t = 0;
    while (!cfg_ready && t < 200) begin @(negedge clk); t++; end
    if (!cfg_ready) begin check_eq("fetch_ready_timeout", {31'b0, cfg_ready}, 1); return; end
    dly = $urandom_range(0, maxd);
    repeat (dly) begin
      start = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (!cfg_ready || prog_clk) stall_bad++;
    end
    start     = 1'b0;
    cfg_data  = b;
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    cfg_data  = 8'($urandom);
  endtask

  task automatic full_load(input int maxd);
    int r0, h0, d0, e0, t;
    logic [L-1:0] pre;
`ifdef PROG_READBACK_EN
    int rn0;
    rn0 = rd_n;
`endif
    pre = chain;
    r0 = rises; h0 = hs_cnt; d0 = dones; e0 = errs;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("start_outputs", {29'b0, busy, prog_en, cfg_ready}, 3'b111);
    for (int b = 0; b < NB; b++) send_byte(stim[b], maxd);
    t = 0;
    while (!done && t < 500) begin @(negedge clk); t++; end
    check_eq("done_seen", {31'b0, done}, 1);
    check_eq("finish_outputs", {28'b0, busy, prog_en, prog_clk, err}, 0);
`ifdef PROG_READBACK_EN
    check_eq("rd_in_finish", {31'b0, rd_valid}, 1);
`endif
    @(negedge clk);
    check_eq("done_single_cycle", {31'b0, done}, 0);
    check_eq("rise_count", rises - r0, L);
    check_eq("handshake_count", hs_cnt - h0, NB);
    check_eq("done_count", dones - d0, 1);
    check_eq("err_count", errs - e0, 0);
    check_eq("chain_contents", 32'(chain), 32'(stream_chain()));
`ifdef PROG_READBACK_EN
    check_eq("rd_count", rd_n - rn0, NB);
    for (int b = 0; b < NB; b++)
      check_eq("rd_data", {24'b0, rd_buf[(rn0 + b) % 16]}, {24'b0, rb_exp(pre, b)});
`endif
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r0, d0, t;
`ifdef PROG_READBACK_EN
    int rn0;
`endif
    repeat (3) @(negedge clk);
    check_eq("reset_outputs",
             {25'b0, busy, done, err, prog_clk, prog_en, cfg_ready, prog_in}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fixed stream with partial final byte, valid always ready.
    stim[0] = 8'hA5; stim[1] = 8'h3C; stim[2] = 8'hFF;
    full_load(0);

    // Randomized streams with random valid delays and ignored starts.
    for (int n = 0; n < 4; n++) begin
      for (int b = 0; b < NB; b++) stim[b] = 8'($urandom);
      full_load(10);
    end

    // Abort after three rises, with a same-cycle start.
    for (int b = 0; b < NB; b++) stim[b] = 8'($urandom);
    r0 = rises; d0 = dones;
`ifdef PROG_READBACK_EN
    rn0 = rd_n;
`endif
    start = 1'b1; @(negedge clk); start = 1'b0;
    send_byte(stim[0], 0);
    t = 0;
    while (!(rises - r0 == 3 && prog_clk) && t < 200) begin @(negedge clk); t++; end
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    check_eq("abort_err", {31'b0, err}, 1);
    check_eq("abort_outputs", {27'b0, busy, prog_en, prog_clk, cfg_ready, done}, 0);
    @(negedge clk);
    check_eq("abort_err_pulse", {30'b0, err, busy}, 0);
    repeat (5) @(negedge clk);
    check_eq("abort_rises", rises - r0, 3);
    check_eq("abort_no_done", dones - d0, 0);
    check_eq("abort_partial_chain", {29'b0, chain[2:0]}, {29'b0, stim[0][0], stim[0][1], stim[0][2]});
`ifdef PROG_READBACK_EN
    check_eq("abort_no_rd", rd_n - rn0, 0);
`endif

    // Abort in IDLE is ignored.
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    check_eq("idle_abort_no_err", {31'b0, err}, 0);

    // Abort wins over a same-cycle handshake.
    r0 = rises;
    start = 1'b1; @(negedge clk); start = 1'b0;
    abort = 1'b1; cfg_valid = 1'b1; cfg_data = 8'hFF;
    @(negedge clk);
    abort = 1'b0; cfg_valid = 1'b0;
    check_eq("abort_vs_hs_err", {31'b0, err}, 1);
    repeat (2 * D + 2) @(negedge clk);
    check_eq("abort_vs_hs_no_rise", rises - r0, 0);

    // Load restarts cleanly after an abort.
    for (int b = 0; b < NB; b++) stim[b] = 8'($urandom);
    full_load(3);

    check_eq("hi_phase_width", bad_hi, 0);
    check_eq("lo_phase_width", bad_lo, 0);
    check_eq("prog_in_hold", bad_hold, 0);
    check_eq("fetch_wait_idle_clk", stall_bad, 0);

    // Asynchronous reset during a high phase.
    start = 1'b1; @(negedge clk); start = 1'b0;
    send_byte(8'h5A, 0);
    t = 0;
    while (!prog_clk && t < 50) begin @(negedge clk); t++; end
    #2 rst_n = 1'b0;
    #1 check_eq("async_reset_outputs", {28'b0, prog_clk, prog_en, busy, cfg_ready}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_reset_idle", {29'b0, busy, cfg_ready, prog_en}, 0);
    for (int b = 0; b < NB; b++) stim[b] = 8'($urandom);
    full_load(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
